// File: rtl/pwm_led_pkg.sv
// Shared encodings and default parameters for the multi-channel PWM LED driver.
package pwm_led_pkg;

    localparam int DEF_CH         = 6;
    localparam int DEF_PW         = 8;
    localparam int DEF_PERIOD     = 255;
    localparam bit DEF_ACTIVE_LOW = 1'b1;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_STATIC  = 2'b01,
        MODE_BREATHE = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Channel-select width; a single channel still needs one address bit.
    function automatic int ch_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/pwm_led_if.sv
// Configuration port of the PWM LED driver.
interface pwm_led_if import pwm_led_pkg::*; #(
    parameter int CH = DEF_CH,
    parameter int PW = DEF_PW
);
    localparam int CHW = ch_w(CH);

    // Handshake: a write transfers on every rising clk edge where cfg_valid and
    // cfg_ready are both 1; the payload must be stable whenever cfg_valid is 1.
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic [1:0]     cfg_mode;
    logic [PW-1:0]  cfg_duty;
    logic [3:0]     cfg_step;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_duty, cfg_step,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_duty, cfg_step,
        output cfg_ready
    );

endinterface

// File: rtl/pwm_led_ch.sv
// One PWM channel: shadow config, active level with breathe sequencer,
// comparator and registered output pin.
module pwm_led_ch import pwm_led_pkg::*; #(
    parameter int PW         = DEF_PW,
    parameter int PERIOD     = DEF_PERIOD,
    parameter bit ACTIVE_LOW = DEF_ACTIVE_LOW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] cnt_i,
    input  logic          commit_i,
    input  logic          wr_en_i,
    input  logic [1:0]    wr_mode_i,
    input  logic [PW-1:0] wr_duty_i,
    input  logic [3:0]    wr_step_i,
    output logic          led_o,
    output logic          dir_o
);

    mode_e         sh_mode_q;
    logic [PW-1:0] sh_duty_q;
    logic [3:0]    sh_step_q;
    mode_e         act_mode_q;
    logic [PW-1:0] lvl_q, lvl_d;
    dir_e          dir_q, dir_d;
    logic          led_q;

    mode_e         new_mode;
    logic [PW-1:0] new_duty;
    logic [3:0]    new_step;
    logic [PW:0]   sum_w;
    logic [PW:0]   diff_w;

    // A write landing on the commit edge bypasses the shadow so it is not lost.
    always_comb begin
        new_mode = wr_en_i ? mode_e'(wr_mode_i) : sh_mode_q;
        new_duty = wr_en_i ? wr_duty_i : sh_duty_q;
        new_step = wr_en_i ? wr_step_i : sh_step_q;
    end

    always_comb begin
        lvl_d  = lvl_q;
        dir_d  = dir_q;
        sum_w  = {1'b0, lvl_q} + (PW+1)'(new_step);
        diff_w = {1'b0, lvl_q} - (PW+1)'(new_step);
        if (new_mode == MODE_STATIC) begin
            lvl_d = new_duty;
            dir_d = DIR_UP;
        end else if (new_mode == MODE_BREATHE) begin
            if (act_mode_q != MODE_BREATHE) begin
                lvl_d = '0;
                dir_d = DIR_UP;
            end else if (lvl_q > new_duty) begin
                lvl_d = new_duty;
                dir_d = DIR_DOWN;
            end else if (dir_q == DIR_UP) begin
                if (sum_w >= {1'b0, new_duty}) begin
                    lvl_d = new_duty;
                    dir_d = DIR_DOWN;
                end else begin
                    lvl_d = sum_w[PW-1:0];
                end
            end else begin
                if ({1'b0, lvl_q} <= (PW+1)'(new_step)) begin
                    lvl_d = '0;
                    dir_d = DIR_UP;
                end else begin
                    lvl_d = diff_w[PW-1:0];
                end
            end
        end else begin
            lvl_d = '0;
            dir_d = DIR_UP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_mode_q  <= MODE_OFF;
            sh_duty_q  <= '0;
            sh_step_q  <= '0;
            act_mode_q <= MODE_OFF;
            lvl_q      <= '0;
            dir_q      <= DIR_UP;
            led_q      <= ACTIVE_LOW;
        end else begin
            if (wr_en_i) begin
                sh_mode_q <= mode_e'(wr_mode_i);
                sh_duty_q <= wr_duty_i;
                sh_step_q <= wr_step_i;
            end
            if (commit_i) begin
                act_mode_q <= new_mode;
                lvl_q      <= lvl_d;
                dir_q      <= dir_d;
            end
            led_q <= (cnt_i < lvl_q) ^ ACTIVE_LOW;
        end
    end

    assign led_o = led_q;
    assign dir_o = (dir_q == DIR_DOWN);

endmodule

// File: rtl/pwm_led_ctrl.sv
// Multi-channel PWM LED driver: shared period counter, config decode and
// per-channel instances committed at each period end.
module pwm_led_ctrl import pwm_led_pkg::*; #(
    parameter int CH         = DEF_CH,
    parameter int PW         = DEF_PW,
    parameter int PERIOD     = DEF_PERIOD,
    parameter bit ACTIVE_LOW = DEF_ACTIVE_LOW
) (
    input  logic          clk,
    input  logic          rst,
    pwm_led_if.slave      cfg,
    output logic [CH-1:0] led,
    output logic          period_tick,
    output logic [CH-1:0] dbg_dir_o
);

    localparam int            CHW  = ch_w(CH);
    localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);

    logic [PW-1:0] cnt_q, cnt_d;
    logic          tick_q;
    logic          rdy_q;
    logic          wr;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end

    // tick_q tracks cnt_q == LAST but is registered so it is glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == LAST);
            rdy_q  <= 1'b1;
        end
    end

    assign cfg.cfg_ready = rdy_q;
    assign period_tick   = tick_q;
    assign wr            = cfg.cfg_valid & rdy_q;

    // Addresses at or above CH match no instance and are silently dropped.
    for (genvar g = 0; g < CH; g++) begin : g_ch
        pwm_led_ch #(
            .PW         (PW),
            .PERIOD     (PERIOD),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .cnt_i     (cnt_q),
            .commit_i  (tick_q),
            .wr_en_i   (wr && (cfg.cfg_ch == CHW'(g))),
            .wr_mode_i (cfg.cfg_mode),
            .wr_duty_i (cfg.cfg_duty),
            .wr_step_i (cfg.cfg_step),
            .led_o     (led[g]),
            .dir_o     (dbg_dir_o[g])
        );
    end

endmodule

// File: doc/pwm_led_ctrl.md
# pwm_led_ctrl

Multi-channel, parametrised PWM LED driver that replaces the fixed 6-bit, all-LEDs-same-duty driver. Each channel has its own duty and mode (off, static, breathe), loaded through a valid/ready config port. New settings are double-buffered and committed only at period end, so the output is glitch-free. The block sits between the sensor/control logic (e.g. the BH1750 brightness path) and the RGB LED pins.

## Interface

- `CH`, default 6: number of LED channels (2 RGB LEDs × 3).
- `PW`, default 8: duty/counter width in bits.
- `PERIOD`, default 255: PWM period in clk cycles; legal range 2..2**PW-1.
- `ACTIVE_LOW`, default 1: 1 means an LED is lit when its pin is 0.
- `clk`, input, 1: system clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `cfg_valid`, input, 1: config write request.
- `cfg_ready`, output, 1: block accepts a write; 0 in reset, 1 otherwise.
- `cfg_ch`, input, $clog2(CH): target channel. A value ≥ CH is accepted and ignored.
- `cfg_mode`, input, 2: 00 OFF, 01 STATIC, 10 BREATHE, 11 reserved (behaves as OFF).
- `cfg_duty`, input, PW: STATIC duty, or BREATHE peak.
- `cfg_step`, input, 4: BREATHE increment per period.
- `led`, output, CH: PWM pins, registered.
- `period_tick`, output, 1: one-cycle pulse on the last cycle of each period.

## Operation

- Counter `cnt` runs 0..PERIOD-1 and wraps to 0. `period_tick` = (cnt == PERIOD-1).
- A write occurs when cfg_valid && cfg_ready. It stores {mode, duty, step} into the shadow registers of `cfg_ch`. Back-to-back writes are allowed; the last write before commit wins.
- Commit happens at every period end (the clock edge where cnt goes PERIOD-1→0): active ← shadow, per channel.
  - A write in the same cycle as the commit is included in that commit.
- Per-channel level `lvl` (PW bits) drives the comparator. The channel is lit when cnt < lvl.
  - lvl = 0 gives always dark. lvl ≥ PERIOD gives always lit.
- OFF: lvl = 0.
- STATIC: lvl = duty, from the commit edge onward.
- BREATHE: states UP and DOWN. Updates are applied at each period-end edge using PW+1-bit arithmetic:
  - UP: lvl ← min(lvl+step, duty). If the result equals duty, go to DOWN.
  - DOWN: lvl ← lvl−step, saturating at 0. If the result is 0, go to UP.
  - step = 0 freezes lvl.
  - duty = 0 holds lvl at 0.
  - Entering BREATHE from another mode resets lvl = 0 and state = UP.
  - If duty is lowered below the current lvl, lvl clamps to the new duty on the commit edge.
- Output: led[i] ← lit ^ ACTIVE_LOW, registered.

## Timing

- Reset values (asynchronous on rst=0):
  - cnt = 0; shadow and active mode = OFF; duty, step and lvl = 0; state = UP.
  - period_tick = 0; cfg_ready = 0; led = {CH{ACTIVE_LOW}}, i.e. all dark.
- The first clock after reset release starts period 0 with cnt = 0.
- cfg_ready rises on the first clk edge after rst deasserts.
- Output latency: led reflects the comparison for cnt = k on the cycle when cnt = k+1. The output is therefore a 1-cycle-delayed copy of the combinational compare.
- Latency from write to effect:
  - A write in a cycle with cnt = k < PERIOD-1 is committed at the next wrap.
  - A write at cnt = PERIOD-1 commits at that same wrap.
  - The new duty first appears on led one cycle after cnt = 0.
- Reset mid-period or mid-breathe returns immediately to the reset values; no partial state is retained.
- There is no back-pressure apart from reset; cfg_ready never drops during normal operation.

## Structure

- Package `pwm_led_pkg` holds:
  - mode encodings MODE_OFF, MODE_STATIC, MODE_BREATHE;
  - the breathe-direction encoding (UP/DOWN);
  - the default-parameter constants.
- Sub-module `pwm_led_ch` is instantiated CH times. Each instance contains one channel's shadow registers, active registers, breathe state machine, comparator and output flop.
- The top level contains the shared counter, period_tick generation, write-address decode and cfg_ready.

## Test plan

- Reset: assert rst at a random cycle → led = 6'b111111, cfg_ready = 0, period_tick = 0. After release, cnt restarts at 0.
- STATIC, ch 0, duty 100, PERIOD 255 → led[0] is low for exactly 100 cycles and high for 155 per period. Other channels stay high.
- Boundaries on ch 1:
  - duty 0 → led[1] constant 1;
  - duty 255 → led[1] constant 0;
  - write at cnt = 254 → new duty visible in the very next period;
  - write at cnt = 10 → old duty persists until the wrap.
- BREATHE, ch 2, duty 40, step 15 → per-period lvl sequence 15, 30, 40, 25, 10, 0, 15…; step 0 freezes lvl.
- Two writes to ch 3 within one period (duty 20, then 200) → only 200 is applied. A write with cfg_ch = 7 changes no output.
- Parameter sweep CH=3, PW=6, PERIOD=63, ACTIVE_LOW=0 → polarity is inverted and duty 63 gives always lit.
